// File: rtl/spad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spad_pkg
// Description : Shared types and default constants for the SPAD front end.
//               Holds the controller state encoding and the default gate
//               length and photon synchronizer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package spad_pkg;

    // Controller states. The width is explicit so the encoding is stable
    // across tools.
    typedef enum logic [1:0] {
        ARMING   = 2'd0,
        ARMED    = 2'd1,
        FIRED    = 2'd2,
        QUENCHED = 2'd3
    } spad_state_e;

    localparam int GATE_LEN_DEF    = 48;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W           = 8;

endpackage : spad_pkg
`default_nettype wire

// File: rtl/spad_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spad_sync_edge
// Description : Brings the asynchronous photon pulse into the clk_i domain
//               through SYNC_STAGES flops, keeps a one-cycle history of the
//               synchronized level and flags a low-to-high transition.
// Ports       : clk_i       - sampling clock
//               rst_sync_n  - reset, asynchronous assert, released
//                             synchronously by the parent (active-low)
//               photon      - asynchronous photon-arrival pulse
//               rise_pulse  - one-cycle flag, synchronized photon rose
// Revision    : 1.0 - initial release
// ============================================================================
module spad_sync_edge
    import spad_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_sync_n,
    input  logic photon,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    // Marks which flops of the chain hold genuinely sampled photon levels.
    // Until the history flop holds a real sample, the reset-cleared zeros
    // would make a photon that was already high look like a fresh edge.
    logic [SYNC_STAGES:0]   r_valid;

    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            r_sync  <= '0;
            r_hist  <= 1'b0;
            r_valid <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], photon};
            r_hist  <= r_sync[SYNC_STAGES-1];
            r_valid <= {r_valid[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_hist & r_valid[SYNC_STAGES];

endmodule : spad_sync_edge
`default_nettype wire

// File: rtl/spad_module.sv
`default_nettype none
// ============================================================================
// Module      : spad_module
// Description : SPAD photon front end. Detects the first photon edge after
//               reset, raises trig (held until reset) and a time_gate pulse
//               of GATE_LEN cycles, then quenches and ignores further photons.
// Ports       : clk_i     - sampling clock
//               rst_auto  - reset, asynchronous, active-low
//               photon    - asynchronous photon-arrival pulse
//               trig      - registered trigger to the TDC
//               time_gate - registered gate pulse, GATE_LEN cycles
// Revision    : 1.0 - initial release
// ============================================================================
module spad_module
    import spad_pkg::*;
#(
    parameter int GATE_LEN    = GATE_LEN_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_auto,
    input  logic photon,
    output logic trig,
    output logic time_gate
);

    localparam logic [CNT_W-1:0] c_gate_len = CNT_W'(GATE_LEN);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             w_rise;
    spad_state_e      r_state;
    spad_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_trig;
    logic             r_gate;
    logic             w_trig_nxt;
    logic             w_gate_nxt;

    // Reset asserts immediately but is released two clk_i edges later, so
    // every downstream flop leaves reset on a clean edge.
    always_ff @(posedge clk_i or negedge rst_auto) begin
        if (!rst_auto) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    spad_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i      (clk_i),
        .rst_sync_n (w_rst_n),
        .photon     (photon),
        .rise_pulse (w_rise)
    );

    // State register; outputs are registered alongside the state so that
    // trig and time_gate come straight from flops.
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ARMING;
            r_cnt   <= '0;
            r_trig  <= 1'b0;
            r_gate  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_trig  <= w_trig_nxt;
            r_gate  <= w_gate_nxt;
        end
    end

    // Next-state logic. The counter holds the gate cycle number: 1 on the
    // cycle the gate opens, GATE_LEN on its last cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ARMING: begin
                w_state_nxt = ARMED;
            end
            ARMED: begin
                if (w_rise) begin
                    w_state_nxt = FIRED;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            FIRED: begin
                if (r_cnt == c_gate_len) begin
                    w_state_nxt = QUENCHED;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            QUENCHED: begin
                w_state_nxt = QUENCHED;
            end
            default: begin
                w_state_nxt = ARMING;
            end
        endcase
    end

    // Output decode from the next state, captured by the state register.
    always_comb begin
        w_trig_nxt = (w_state_nxt == FIRED) || (w_state_nxt == QUENCHED);
        w_gate_nxt = (w_state_nxt == FIRED);
    end

    assign trig      = r_trig;
    assign time_gate = r_gate;

endmodule : spad_module
`default_nettype wire

// File: tb/tb_spad_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_spad_module
// Description : Self-checking bench for spad_module. Two instances share the
//               stimulus: (GATE_LEN=48, SYNC_STAGES=2) and (GATE_LEN=1,
//               SYNC_STAGES=3). A sample-history reference model predicts
//               trig/time_gate every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spad_module;

    localparam int GL[2] = '{48, 1};
    localparam int SS[2] = '{2, 3};

    logic clk_i    = 1'b0;
    logic rst_auto = 1'b0;
    logic photon   = 1'b0;
    logic trig0, gate0, trig1, gate1;

    always #5 clk_i = ~clk_i;

    spad_module #(.GATE_LEN(48), .SYNC_STAGES(2)) u_dut0 (
        .clk_i     (clk_i),
        .rst_auto  (rst_auto),
        .photon    (photon),
        .trig      (trig0),
        .time_gate (gate0)
    );

    spad_module #(.GATE_LEN(1), .SYNC_STAGES(3)) u_dut1 (
        .clk_i     (clk_i),
        .rst_auto  (rst_auto),
        .photon    (photon),
        .trig      (trig1),
        .time_gate (gate1)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: k counts clk_i edges since rst_auto release,
    // pq[k-1] is the photon level sampled on edge k. The two edges after
    // release belong to the reset deassertion synchronizer; edge 3 is the
    // first functional (ARMING) edge. An event is a 0->1 pair of samples
    // both taken on functional edges, seen SYNC_STAGES edges later.
    int k = 0;
    bit pq[$];
    bit fired[2];
    int fire_k[2];
    int run[2];
    int rises[2];
    bit prev_trig[2];

    task automatic check(string tag, logic obs, logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [1:0] ot;
        logic [1:0] og;
        bit et;
        bit eg;
        @(posedge clk_i);
        if (rst_auto) begin
            k++;
            pq.push_back(photon);
        end
        for (int i = 0; i < 2; i++) begin
            if (!fired[i] && k >= SS[i] + 4 && pq[k-SS[i]-1] && !pq[k-SS[i]-2]) begin
                fired[i]  = 1'b1;
                fire_k[i] = k;
            end
        end
        #1;
        ot = {trig1, trig0};
        og = {gate1, gate0};
        for (int i = 0; i < 2; i++) begin
            et = fired[i];
            eg = fired[i] && ((k - fire_k[i]) < GL[i]);
            check($sformatf("trig%0d", i), ot[i], et);
            check($sformatf("gate%0d", i), og[i], eg);
            if (ot[i] && !prev_trig[i]) rises[i]++;
            prev_trig[i] = ot[i];
            if (og[i]) begin
                run[i]++;
            end else if (run[i] > 0) begin
                check_int($sformatf("gate_width%0d", i), run[i], GL[i]);
                run[i] = 0;
            end
        end
    endtask

    task automatic set_photon(logic v);
        @(negedge clk_i);
        photon = v;
    endtask

    // Asserts reset mid-cycle, checks the outputs clear before any edge,
    // closes the scoreboard window and holds reset for 'hold' edges.
    task automatic do_reset(int hold);
        @(negedge clk_i);
        #2;
        rst_auto = 1'b0;
        #1;
        check("rst_imm_trig0", trig0, 1'b0);
        check("rst_imm_gate0", gate0, 1'b0);
        check("rst_imm_trig1", trig1, 1'b0);
        check("rst_imm_gate1", gate1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check_int($sformatf("window_rises%0d", i), rises[i], fired[i] ? 1 : 0);
            fired[i]     = 1'b0;
            run[i]       = 0;
            rises[i]     = 0;
            prev_trig[i] = 1'b0;
        end
        k = 0;
        pq.delete();
        repeat (hold) tick();
        @(negedge clk_i);
        rst_auto = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        // Reset state and first photon: latency and gate length
        repeat (3) tick();
        check("reset_trig0", trig0, 1'b0);
        check("reset_gate0", gate0, 1'b0);
        @(negedge clk_i);
        rst_auto = 1'b1;
        repeat (6) tick();
        set_photon(1'b1);
        tick();
        tick();
        check("lat_edge2_trig0", trig0, 1'b0);
        tick();
        check("lat_edge3_trig0", trig0, 1'b1);
        check("lat_edge3_gate0", gate0, 1'b1);
        check("lat_edge3_trig1", trig1, 1'b0);
        tick();
        check("lat_edge4_trig1", trig1, 1'b1);
        check("lat_edge4_gate1", gate1, 1'b1);
        tick();
        check("gate1_one_cycle", gate1, 1'b0);
        set_photon(1'b0);

        // Extra photon pulses during the gate and after quench
        repeat (15) tick();
        set_photon(1'b1);
        repeat (3) tick();
        set_photon(1'b0);
        repeat (40) tick();
        check("quench_gate0", gate0, 1'b0);
        repeat (50) tick();
        set_photon(1'b1);
        repeat (4) tick();
        set_photon(1'b0);
        repeat (10) tick();
        check("quench_trig0_held", trig0, 1'b1);

        // Reset in the middle of a gate, then a full gate again
        do_reset(3);
        repeat (6) tick();
        set_photon(1'b1);
        repeat (4) tick();
        set_photon(1'b0);
        repeat (8) tick();
        do_reset(3);
        repeat (6) tick();
        set_photon(1'b1);
        repeat (5) tick();
        set_photon(1'b0);
        repeat (60) tick();

        // Photon held high across reset release
        set_photon(1'b1);
        do_reset(3);
        repeat (10) tick();
        check("held_high_no_trig0", trig0, 1'b0);
        check("held_high_no_trig1", trig1, 1'b0);
        set_photon(1'b0);
        repeat (2) tick();
        set_photon(1'b1);
        tick();
        tick();
        check("fresh_edge2_trig0", trig0, 1'b0);
        tick();
        check("fresh_edge3_trig0", trig0, 1'b1);
        repeat (55) tick();
        set_photon(1'b0);

        // Randomized windows: reset between events, random photon delay
        for (int it = 0; it < 10; it++) begin
            set_photon(1'b0);
            do_reset($urandom_range(1, 4));
            d = $urandom_range(0, 1000);
            repeat (d / 10) tick();
            set_photon(1'b1);
            repeat ($urandom_range(1, 6)) tick();
            set_photon(1'b0);
            repeat ($urandom_range(5, 30)) tick();
            set_photon(1'b1);
            repeat ($urandom_range(1, 4)) tick();
            set_photon(1'b0);
            repeat ($urandom_range(10, 70)) tick();
        end
        do_reset(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_spad_module
`default_nettype wire

// File: doc/spad_module.md
SPAD_MODULE -- requirements
Module: spad_module

Interface
REQ-001 Parameter GATE_LEN, default 48, time_gate pulse length in clk_i cycles (range 1..255).
REQ-002 Parameter SYNC_STAGES, default 2, photon synchronizer depth (range 2..3).
REQ-003 clk_i  input  1  sampling clock; all state changes on its rising edge except reset.
REQ-004 rst_auto  input  1  reset, asynchronous, active-low.
REQ-005 photon  input  1  asynchronous photon-arrival pulse; rising edge = event.
REQ-006 trig  output  1  registered trigger to TDC; high from event until reset.
REQ-007 time_gate  output  1  registered gate pulse, GATE_LEN cycles, starts with trig.

Function
REQ-008 photon SHALL pass through SYNC_STAGES flip-flops clocked by clk_i before any use.
REQ-009 Event = synchronized photon high in the current cycle and low in the previous cycle.
REQ-010 States SHALL be ARMING, ARMED, FIRED and QUENCHED.
REQ-011 ARMING: entered on reset; lasts one cycle to load the edge history; it detects no events; then goes to ARMED.
REQ-012 ARMED: trig=0, time_gate=0; an event moves the state to FIRED.
REQ-013 Latency: with SYNC_STAGES=2, trig and time_gate SHALL rise on the 3rd rising clk_i edge after photon first meets setup.
REQ-014 FIRED: trig=1, time_gate=1; an 8-bit gate counter counts GATE_LEN cycles; at GATE_LEN the state goes to QUENCHED.
REQ-015 QUENCHED: trig=1, time_gate=0; the state holds until rst_auto is asserted.
REQ-016 Photon edges in FIRED or QUENCHED SHALL be ignored and SHALL NOT be queued or extend the gate.
REQ-017 A photon already high when reset is released SHALL NOT create an event; a fresh low-to-high transition is needed.
REQ-018 Photon pulses shorter than one clk_i period may be missed; no requirement exists to capture them.
REQ-019 trig and time_gate SHALL be driven directly from flip-flops, with no combinational path from photon.

Reset
REQ-020 Asserting rst_auto low SHALL immediately clear trig=0, time_gate=0, the gate counter, all synchronizer/history flops and the state, independent of clk_i.
REQ-021 Reset asserted in FIRED SHALL truncate time_gate at once.
REQ-022 After release, the state SHALL be ARMING for the first clk_i edge, then ARMED.
REQ-023 Reset SHALL be released synchronously inside the block through a 2-flop deassertion synchronizer on clk_i; assertion stays asynchronous.

Structure
REQ-024 Package spad_pkg SHALL hold the state enum (ARMING/ARMED/FIRED/QUENCHED) and the default constants GATE_LEN_DEF=48 and SYNC_STAGES_DEF=2.
REQ-025 The single sub-module spad_sync_edge SHALL contain the synchronizer, history flop and rise detector, with output rise_pulse.
REQ-026 The state machine and gate counter SHALL be in spad_module.

Verification
REQ-027 Reset, release, photon 0->1 held 5 cycles -> trig and time_gate rise on the 3rd clk_i edge; time_gate stays high exactly 48 cycles; trig stays 1.
REQ-028 After REQ-027, a second photon pulse at cycle 20 of the gate and another at cycle 100 -> no change to trig; time_gate still falls at cycle 48.
REQ-029 rst_auto low at gate cycle 10 -> trig=0 and time_gate=0 immediately, before any clk_i edge; after release, a new photon gives a normal 48-cycle gate.
REQ-030 Photon held high across reset release -> no trig; photon low 2 cycles then high -> trig after 3 edges.
REQ-031 Scoreboard over 10 random cycles: photon delay 0..1000 ns, reset via rst_auto between events -> exactly one trig rise per armed window, and every time_gate width = 48 cycles unless truncated by reset.
REQ-032 With GATE_LEN=1 and SYNC_STAGES=3 -> trig rises on the 4th edge; time_gate lasts exactly 1 cycle.
